corg_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the CORG processor's single-ported unified memory between the instruction-fetch stage and the load/store (data) stage. It grants one access at a time, issues it to memory, and returns read data or a write acknowledge to the owner after a fixed memory latency. It sits between the processor's fetch/MEM stages and the memory macro and generates the fetch stall.

---
 rtl/corg_mem_arbiter_pkg.sv | 19 +
 rtl/corg_starve_ctr.sv | 43 ++++
 rtl/corg_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_corg_mem_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/corg_mem_arbiter_pkg.sv
// Shared types and default widths for the CORG memory-side blocks.
// Holds the arbiter state encoding and the request-owner encoding.
package corg_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/corg_starve_ctr.sv
// Saturating starvation counter with clear, increment and registered at-max flag.
// Clear dominates increment; the count never passes MAX.
module corg_starve_ctr #(
    parameter int MAX = 4,
    parameter int W   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_nxt_s;
    logic         at_max_r;

    // Next count: clear wins, otherwise step up until MAX is reached.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = {W{1'b0}};
        end else if (inc && (cnt_r != W'(MAX))) begin
            cnt_nxt_s = cnt_r + W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count and at-max flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r    <= {W{1'b0}};
            at_max_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            at_max_r <= (cnt_nxt_s == W'(MAX));
        end
    end

    assign at_max = at_max_r;

endmodule

// File: rtl/corg_mem_arbiter.sv
// Fetch/data arbiter for the CORG single-ported unified memory.
// One access in flight; data has priority unless fetch has been starved STARVE_MAX times.
module corg_mem_arbiter
    import corg_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              busy
);

    arb_state_t        state_r;
    owner_t            owner_r;
    logic [3:0]        lat_cnt_r;
    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;

    logic win_s;
    logic last_s;
    logic force_if_s;
    logic starved_s;
    logic d_gnt_s;
    logic if_gnt_s;
    logic gnt_any_s;

    corg_starve_ctr #(
        .MAX (STARVE_MAX),
        .W   (4)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .clr    (if_gnt_s | ~if_req),
        .inc    (d_gnt_s & if_req),
        .at_max (starved_s)
    );

    // The final WAIT cycle doubles as the next grant window so accesses run back-to-back.
    assign last_s     = (state_r == WAIT) && (lat_cnt_r == 4'd0);
    assign win_s      = ((state_r == IDLE) || last_s) && !reset;
    assign force_if_s = if_req && starved_s;
    assign d_gnt_s    = win_s && d_req && !force_if_s;
    assign if_gnt_s   = win_s && if_req && !d_gnt_s;
    assign gnt_any_s  = d_gnt_s | if_gnt_s;

    // Arbiter FSM with registered memory-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            owner_r     <= OWN_IF;
            lat_cnt_r   <= 4'd0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else if (gnt_any_s) begin
            state_r     <= ISSUE;
            owner_r     <= d_gnt_s ? OWN_D : OWN_IF;
            mem_en_r    <= 1'b1;
            mem_we_r    <= d_gnt_s & d_we;
            mem_addr_r  <= d_gnt_s ? d_addr : if_addr;
            mem_wdata_r <= d_gnt_s ? d_wdata : {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                ISSUE: begin
                    mem_en_r  <= 1'b0;
                    mem_we_r  <= 1'b0;
                    lat_cnt_r <= 4'(MEM_LAT - 1);
                    state_r   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt_r == 4'd0) begin
                        state_r <= IDLE;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    mem_en_r <= 1'b0;
                    mem_we_r <= 1'b0;
                end
            endcase
        end
    end

    assign if_gnt    = if_gnt_s;
    assign d_gnt     = d_gnt_s;
    assign if_rvalid = last_s && (owner_r == OWN_IF);
    assign d_rvalid  = last_s && (owner_r == OWN_D);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign stall_if  = if_req && !if_gnt_s;
    assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_corg_mem_arbiter.sv
// Directed bench for corg_mem_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3,
// both STARVE_MAX=4, sharing the request-side stimulus.
module tb_corg_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] mem_rdata;

    logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_en1, mem_we1, stall_if1, busy1;
    logic [15:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
    logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3, stall_if3, busy3;
    logic [15:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    corg_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata), .stall_if(stall_if1), .busy(busy1)
    );

    corg_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata), .stall_if(stall_if3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    logic exp_d;
    logic win_if [9];

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = 16'h0000; d_req = 1'b0; d_we = 1'b0;
        d_addr = 16'h0000; d_wdata = 16'h0000; mem_rdata = 16'h0000;
        // Reset state, including grant suppression with both requests high.
        idle(2);
        if_req = 1'b1; d_req = 1'b1;
        #1;
        chk("rst_if_gnt", {31'd0, if_gnt1}, 32'd0);
        chk("rst_d_gnt", {31'd0, d_gnt1}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en1}, 32'd0);
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr1}, 32'd0);
        chk("rst_rvalid", {30'd0, if_rvalid1, d_rvalid1}, 32'd0);
        if_req = 1'b0; d_req = 1'b0;
        cyc();
        reset = 1'b0;
        idle(2);

        // Single fetch, MEM_LAT=1.
        if_req = 1'b1; if_addr = 16'h0010; mem_rdata = 16'hBEEF;
        #1;
        chk("f_gnt", {31'd0, if_gnt1}, 32'd1);
        chk("f_stall", {31'd0, stall_if1}, 32'd0);
        chk("f_busy0", {31'd0, busy1}, 32'd0);
        cyc();
        if_req = 1'b0;
        #1;
        chk("f_mem_en", {31'd0, mem_en1}, 32'd1);
        chk("f_mem_addr", {16'd0, mem_addr1}, 32'h0010);
        chk("f_mem_we", {31'd0, mem_we1}, 32'd0);
        chk("f_busy1", {31'd0, busy1}, 32'd1);
        chk("f_rv_early", {31'd0, if_rvalid1}, 32'd0);
        cyc();
        chk("f_rvalid", {31'd0, if_rvalid1}, 32'd1);
        chk("f_rdata", {16'd0, if_rdata1}, 32'hBEEF);
        chk("f_d_rvalid", {31'd0, d_rvalid1}, 32'd0);
        chk("f_busy2", {31'd0, busy1}, 32'd1);
        chk("f_mem_en_off", {31'd0, mem_en1}, 32'd0);
        cyc();
        chk("f_rv_once", {31'd0, if_rvalid1}, 32'd0);
        chk("f_busy3", {31'd0, busy1}, 32'd0);
        idle(4);

        // Data write.
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
        #1;
        chk("w_gnt", {31'd0, d_gnt1}, 32'd1);
        cyc();
        d_req = 1'b0;
        #1;
        chk("w_mem_en", {31'd0, mem_en1}, 32'd1);
        chk("w_mem_we", {31'd0, mem_we1}, 32'd1);
        chk("w_mem_addr", {16'd0, mem_addr1}, 32'h0200);
        chk("w_mem_wdata", {16'd0, mem_wdata1}, 32'h1234);
        cyc();
        chk("w_ack", {31'd0, d_rvalid1}, 32'd1);
        chk("w_if_rv", {31'd0, if_rvalid1}, 32'd0);
        d_we = 1'b0;
        idle(5);

        // Contention on the MEM_LAT=1 instance: four data grants, then fetch, then data.
        if_req = 1'b1; if_addr = 16'h0100; d_req = 1'b1; d_addr = 16'h0300;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (k % 2 == 0) begin
                exp_d = ((k / 2) != 4);
                chk($sformatf("c_d_gnt_%0d", k), {31'd0, d_gnt1}, {31'd0, exp_d});
                chk($sformatf("c_if_gnt_%0d", k), {31'd0, if_gnt1}, {31'd0, ~exp_d});
                chk($sformatf("c_stall_%0d", k), {31'd0, stall_if1}, {31'd0, exp_d});
            end else begin
                chk($sformatf("c_gap_%0d", k), {30'd0, d_gnt1, if_gnt1}, 32'd0);
                chk($sformatf("c_gstall_%0d", k), {31'd0, stall_if1}, 32'd1);
            end
            cyc();
        end
        if_req = 1'b0; d_req = 1'b0;
        idle(6);

        // Back-to-back reads on the MEM_LAT=3 instance.
        d_req = 1'b1; d_addr = 16'h0400; mem_rdata = 16'hCAFE;
        for (int k = 0; k < 13; k++) begin
            #1;
            chk($sformatf("b_gnt_%0d", k), {31'd0, d_gnt3}, {31'd0, (k % 4 == 0)});
            chk($sformatf("b_rv_%0d", k), {31'd0, d_rvalid3}, {31'd0, (k % 4 == 0) && (k > 0)});
            if (k == 4) chk("b_rdata", {16'd0, d_rdata3}, 32'hCAFE);
            cyc();
        end
        d_req = 1'b0;
        idle(6);

        // Reset in WAIT with a read outstanding on the MEM_LAT=3 instance.
        d_req = 1'b1; d_addr = 16'h0600;
        #1;
        chk("r_gnt", {31'd0, d_gnt3}, 32'd1);
        cyc();
        d_req = 1'b0;
        #1;
        chk("r_issue", {31'd0, mem_en3}, 32'd1);
        cyc();
        chk("r_wait_busy", {31'd0, busy3}, 32'd1);
        reset = 1'b1;
        #1;
        chk("r_busy", {31'd0, busy3}, 32'd0);
        chk("r_mem_en", {31'd0, mem_en3}, 32'd0);
        d_req = 1'b1;
        #1;
        chk("r_gnt_blk", {31'd0, d_gnt3}, 32'd0);
        d_req = 1'b0;
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("r_no_rv_%0d", k), {31'd0, d_rvalid3}, 32'd0);
            cyc();
        end
        d_req = 1'b1; d_addr = 16'h0500; mem_rdata = 16'h5A5A;
        #1;
        chk("r2_gnt", {31'd0, d_gnt3}, 32'd1);
        cyc();
        d_req = 1'b0;
        #1;
        chk("r2_mem_en", {31'd0, mem_en3}, 32'd1);
        chk("r2_mem_addr", {16'd0, mem_addr3}, 32'h0500);
        idle(3);
        chk("r2_rvalid", {31'd0, d_rvalid3}, 32'd1);
        chk("r2_rdata", {16'd0, d_rdata3}, 32'h5A5A);
        idle(6);

        // Fetch withdrawn while data busy: starvation count restarts from zero.
        win_if = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        d_req = 1'b1; d_addr = 16'h0700; if_addr = 16'h0800;
        for (int w = 0; w < 9; w++) begin
            if_req = win_if[w];
            #1;
            exp_d = (w != 8);
            chk($sformatf("s_d_gnt_%0d", w), {31'd0, d_gnt1}, {31'd0, exp_d});
            chk($sformatf("s_if_gnt_%0d", w), {31'd0, if_gnt1}, {31'd0, ~exp_d});
            cyc();
            if (w == 2) chk("s_no_fetch", {16'd0, mem_addr1}, 32'h0700);
            cyc();
        end
        if_req = 1'b0; d_req = 1'b0;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
